// File: rtl/ptrans_write_buffer.sv
// ptrans_write_buffer
//
// Output stage of the projective transform. Each flagged pixel has its
// destination coordinates turned into a linear frame-buffer address
// (y*H_RES + x). The {addr, pixel} pair is then queued in a small FIFO, and
// the FIFO drains into the shared ZBT write port whenever the arbiter grants.
// The producer receives no back-pressure. A pixel that arrives while the FIFO
// is full, with no pop on the same edge, is dropped and sets the sticky
// overflow flag.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   pixel_in       [17:0] transformed pixel value
//   pixel_x        [9:0]  destination column
//   pixel_y        [8:0]  destination row
//   pixel_in_flag  qualifier for pixel_in/pixel_x/pixel_y
//   frame_flag     pulse: last pixel of the frame has been sent
//   mem_grant      arbiter allows a write this cycle
//   mem_we         write strobe, one cycle per word
//   mem_addr       [18:0] word address
//   mem_data       [17:0] write data
//   buf_full       FIFO holds 2^DEPTH_LOG2 entries (registered)
//   overflow       sticky: a pixel was lost to a full FIFO
//   frame_written  pulse: frame fully committed to memory
//
// Build option:
//   PTW_BOUNDS_CHECK_EN  when defined, pixels with x >= H_RES or y >= V_RES
//                        are dropped in stage 1 and do not affect overflow.
//
// FSM states:
//   state | meaning
//   RUN   | normal operation, waiting for frame_flag
//   FLUSH | frame ended at the producer; drain until stage 1 and FIFO are empty

module ptrans_write_buffer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] pixel_in,
    input  logic [9:0]  pixel_x,
    input  logic [8:0]  pixel_y,
    input  logic        pixel_in_flag,
    input  logic        frame_flag,
    input  logic        mem_grant,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [17:0] mem_data,
    output logic        buf_full,
    output logic        overflow,
    output logic        frame_written
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Address computation
    // ------------------------------------------------------------------
    logic [18:0] x_ext;
    logic [18:0] y_ext;
    logic [18:0] addr_calc;

    assign x_ext = {9'd0, pixel_x};
    assign y_ext = {10'd0, pixel_y};

    generate
        if (H_RES == 640) begin : g_addr_640
            // 640 = 512 + 128, so the product reduces to two shifts.
            assign addr_calc = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin : g_addr_mul
            localparam logic [18:0] H_RES_W = 19'(H_RES);
            assign addr_calc = (y_ext * H_RES_W) + x_ext;
        end
    endgenerate

    logic accept;

`ifdef PTW_BOUNDS_CHECK_EN
    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [10:0] V_LIM = 11'(V_RES);
    logic in_range;
    assign in_range = ({1'b0, pixel_x} < H_LIM) && ({2'b00, pixel_y} < V_LIM);
    assign accept   = pixel_in_flag && in_range;
`else
    // Unchecked build: the address wraps modulo 2^19 for bad coordinates.
    assign accept = pixel_in_flag;
`endif

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic        v1;
    logic [18:0] s1_addr;
    logic [17:0] s1_pixel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1       <= 1'b0;
            s1_addr  <= 19'd0;
            s1_pixel <= 18'd0;
        end else begin
            v1 <= accept;
            if (accept) begin
                s1_addr  <= addr_calc;
                s1_pixel <= pixel_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [36:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [36:0]      head;

    assign fifo_full = (count == FULL_CNT);
    assign pop       = (count != '0) && mem_grant;
    // A full FIFO still accepts the push when a pop frees a slot on the same edge.
    assign push      = v1 && (!fifo_full || pop);
    assign drop      = v1 && fifo_full && !pop;
    assign head      = fifo_mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Storage has no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s1_addr, s1_pixel};
        end
    end

    // ------------------------------------------------------------------
    // Frame-end FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   fw_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fw_next    = 1'b0;
        case (state)
            RUN: begin
                if (frame_flag) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // count is the registered value, so the pulse lands at
                // least one cycle after the last mem_we.
                if (!v1 && (count == '0)) begin
                    fw_next    = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, status and write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            buf_full      <= 1'b0;
            overflow      <= 1'b0;
            frame_written <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 19'd0;
            mem_data      <= 18'd0;
        end else begin
            count         <= count_next;
            buf_full      <= (count_next == FULL_CNT);
            frame_written <= fw_next;
            mem_we        <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                mem_addr <= head[36:18];
                mem_data <= head[17:0];
            end
            if (fw_next) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ptrans_write_buffer.sv
module tb_ptrans_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] pixel_in;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic        pixel_in_flag;
    logic        frame_flag;
    logic        mem_grant;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [17:0] mem_data;
    logic        buf_full;
    logic        overflow;
    logic        frame_written;

    int errors = 0;
    int checks = 0;
    int writes = 0;

    logic [36:0] sb [$];

    always #5 clk = ~clk;

    ptrans_write_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .pixel_in      (pixel_in),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .pixel_in_flag (pixel_in_flag),
        .frame_flag    (frame_flag),
        .mem_grant     (mem_grant),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .buf_full      (buf_full),
        .overflow      (overflow),
        .frame_written (frame_written)
    );

    // Scoreboard monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [36:0] exp_e;
            writes++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: addr=%0d data=%h, required no write", mem_addr, mem_data);
            end else begin
                exp_e = sb.pop_front();
                if ({mem_addr, mem_data} !== exp_e) begin
                    errors++;
                    $display("FAIL write_order: addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_data, exp_e[36:18], exp_e[17:0]);
                end
            end
        end
    end

    function automatic logic [18:0] model_addr(input int x, input int y);
        int a;
        a = y * 640 + x;
        return a[18:0];
    endfunction

    // Presents one pixel for exactly one rising edge; returns 1 time unit after it.
    task automatic send_pixel(input int x, input int y, input logic [17:0] d, input bit expect_write);
        @(negedge clk);
        pixel_x       = x[9:0];
        pixel_y       = y[8:0];
        pixel_in      = d;
        pixel_in_flag = 1'b1;
        if (expect_write) sb.push_back({model_addr(x, y), d});
        @(posedge clk);
        #1;
        pixel_in_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int c;
        c = 0;
        while (writes < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #2;
        checks++;
        if (writes < target) begin
            errors++;
            $display("FAIL %s_timeout: writes=%0d, required %0d", name, writes, target);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({mem_we, mem_addr, mem_data, buf_full, overflow, frame_written} !== 41'd0) begin
            errors++;
            $display("FAIL %s: we=%b addr=%0d data=%h full=%b ovf=%b fw=%b, required all 0",
                     name, mem_we, mem_addr, mem_data, buf_full, overflow, frame_written);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        pixel_in = '0; pixel_x = '0; pixel_y = '0;
        pixel_in_flag = 1'b0; frame_flag = 1'b0; mem_grant = 1'b0;
        idle(3);
        check_all_zero("reset_outputs");
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_single;
        int w0;
        w0 = writes;
        mem_grant = 1'b1;
        send_pixel(5, 2, 18'h2ABCD, 1'b1);            // after edge N
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL single_lat_n: mem_we=%b, required 0", mem_we); end
        idle(1);                                       // after edge N+1
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL single_lat_n1: mem_we=%b, required 0", mem_we); end
        idle(1);                                       // after edge N+2
        checks++;
        if ({mem_we, mem_addr, mem_data} !== {1'b1, 19'd1285, 18'h2ABCD}) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d data=%h, required we=1 addr=1285 data=2abcd",
                     mem_we, mem_addr, mem_data);
        end
        idle(1);
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL single_one_pulse: mem_we=%b, required 0", mem_we); end
        idle(2);
        checks++;
        if (writes - w0 !== 1) begin errors++; $display("FAIL single_count: writes=%0d, required 1", writes - w0); end
    endtask

    task automatic test_full_push_pop;
        int w0;
        w0 = writes;
        mem_grant = 1'b0;
        for (int i = 0; i < 9; i++) send_pixel(10 + i, 3 + i, 18'($urandom_range(0, 262143)), 1'b1);
        checks++;
        if (buf_full !== 1'b1) begin errors++; $display("FAIL pp_full: buf_full=%b, required 1", buf_full); end
        mem_grant = 1'b1;                              // pop and 9th push share the next edge
        idle(1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: overflow=%b, required 0", overflow); end
        wait_writes(w0 + 9, 30, "pp");
        idle(3);
        checks++;
        if (writes - w0 !== 9 || sb.size() != 0) begin
            errors++;
            $display("FAIL pp_total: writes=%0d pending=%0d, required 9 and 0", writes - w0, sb.size());
        end
    endtask

    task automatic test_burst_overflow;
        int w0;
        w0 = writes;
        mem_grant = 1'b0;
        for (int i = 0; i < 8; i++) send_pixel(100 + i * 7, 200 + i, 18'($urandom_range(0, 262143)), 1'b1);
        idle(1);
        checks++;
        if ({buf_full, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL burst_full: buf_full=%b overflow=%b, required 1 0", buf_full, overflow);
        end
        send_pixel(639, 479, 18'h3FFFF, 1'b0);         // lost: not expected in memory
        idle(1);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow: overflow=%b, required 1", overflow); end
        mem_grant = 1'b1;
        wait_writes(w0 + 8, 30, "burst");
        idle(4);
        checks++;
        if (writes - w0 !== 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL burst_total: writes=%0d pending=%0d, required 8 and 0", writes - w0, sb.size());
        end
        checks++;
        if ({buf_full, overflow} !== 2'b01) begin
            errors++;
            $display("FAIL burst_sticky: buf_full=%b overflow=%b, required 0 1", buf_full, overflow);
        end
    endtask

    task automatic test_frame_end;
        int we_n, fw_n, last_we, fw_cyc;
        logic ov_at_fw;
        we_n = 0; fw_n = 0; last_we = -10; fw_cyc = -1; ov_at_fw = 1'bx;
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) send_pixel(i, 400 + i, 18'(i * 1111 + 7), 1'b1);
        idle(2);
        checks++;
        if (frame_written !== 1'b0) begin errors++; $display("FAIL frame_early: frame_written=%b, required 0", frame_written); end
        @(negedge clk);
        frame_flag = 1'b1;
        mem_grant  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            frame_flag = 1'b0;
            if (mem_we === 1'b1) begin we_n++; last_we = cyc; end
            if (frame_written === 1'b1) begin fw_n++; fw_cyc = cyc; ov_at_fw = overflow; end
            mem_grant = ~mem_grant;
        end
        mem_grant = 1'b1;
        checks++;
        if (we_n !== 3) begin errors++; $display("FAIL frame_writes: writes=%0d, required 3", we_n); end
        checks++;
        if (fw_n !== 1) begin errors++; $display("FAIL frame_pulses: pulses=%0d, required 1", fw_n); end
        checks++;
        if (fw_cyc !== last_we + 1) begin
            errors++;
            $display("FAIL frame_timing: pulse cycle=%0d, required %0d", fw_cyc, last_we + 1);
        end
        checks++;
        if (ov_at_fw !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL frame_ovf_clear: overflow=%b/%b, required 0", ov_at_fw, overflow);
        end
    endtask

    task automatic test_bounds;
        int w0, exp_n;
        w0 = writes;
        mem_grant = 1'b1;
`ifdef PTW_BOUNDS_CHECK_EN
        exp_n = 0;
        send_pixel(640, 0, 18'h15A5A, 1'b0);
`else
        exp_n = 1;
        send_pixel(640, 0, 18'h15A5A, 1'b1);           // model gives addr 640
`endif
        idle(8);
        checks++;
        if (writes - w0 !== exp_n || sb.size() != 0) begin
            errors++;
            $display("FAIL bounds: writes=%0d pending=%0d, required %0d and 0", writes - w0, sb.size(), exp_n);
        end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL bounds_ovf: overflow=%b, required 0", overflow); end
    endtask

    task automatic test_reset_mid_burst;
        int w0;
        mem_grant = 1'b0;
        for (int i = 0; i < 4; i++) send_pixel(300 + i, 100, 18'(i + 1), 1'b0);
        idle(1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid_async");
        mem_grant = 1'b1;
        idle(2);
        check_all_zero("rst_mid_held");
        w0 = writes;
        @(negedge clk);
        reset = 1'b0;
        idle(10);
        checks++;
        if (writes - w0 !== 0 || buf_full !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drain: writes=%0d buf_full=%b, required 0 0", writes - w0, buf_full);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_full_push_pop;
        test_burst_overflow;
        test_frame_end;
        test_bounds;
        test_reset_mid_burst;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
